// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control bundle through ID/EX, EX/MEM and
// MEM/WB. It also produces the load-use stall, the taken-branch IF/ID flush
// and the EX operand forwarding selects.
//
// Handshake note: there is no valid/ready back-pressure here. EX/MEM and
// MEM/WB advance every cycle. The only flow control is `stall`: while it is
// high, upstream holds PC and IF/ID and presents the same ID instruction on
// the next cycle, while ID/EX takes a bubble.
module ctrl_pipe #(
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic [2:0]    id_alu_op,
   input  logic          id_alu_src,
   input  logic          id_reg_wen,
   input  logic          id_reg_dst,
   input  logic          id_mem_ren,
   input  logic          id_mem_wen,
   input  logic          id_mem_to_reg,
   input  logic          id_branch,
   input  logic [RW-1:0] id_rs1,
   input  logic [RW-1:0] id_rs2,
   input  logic [RW-1:0] id_rd,
   input  logic          ex_taken,
   output logic          ex_valid,
   output logic [2:0]    ex_alu_op,
   output logic          ex_alu_src,
   output logic          ex_reg_dst,
   output logic          ex_branch,
   output logic          mem_valid,
   output logic          mem_ren,
   output logic          mem_wen,
   output logic          wb_valid,
   output logic          wb_reg_wen,
   output logic          wb_mem_to_reg,
   output logic [RW-1:0] wb_rd,
   output logic          stall,
   output logic          flush_ifid,
   output logic [1:0]    fwd_a,
   output logic [1:0]    fwd_b
);

   // ALU op a bubble carries; the datapath decodes 3'b000 as ADD.
   localparam logic [2:0] ALU_ADD = 3'b000;

   // Forwarding select encodings.
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic          valid;
      logic [2:0]    alu_op;
      logic          alu_src;
      logic          reg_wen;
      logic          reg_dst;
      logic          mem_ren;
      logic          mem_wen;
      logic          mem_to_reg;
      logic          branch;
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
      logic [RW-1:0] rd;
   } stage_t;

   // A bubble is harmless in every stage: no strobes, no writeback, no branch.
   function automatic stage_t bubble();
      stage_t b;
      b            = '0;
      b.alu_op     = ALU_ADD;
      b.mem_to_reg = 1'b1;
      return b;
   endfunction

   // Forwarding source for one EX operand. A load in MEM is not a source
   // because its data does not exist yet. The load-use stall guarantees
   // that the load has reached WB before its consumer is in EX.
   function automatic logic [1:0] fwd_sel(input stage_t ex,
                                          input stage_t mem,
                                          input stage_t wb,
                                          input logic [RW-1:0] rs);
      logic [1:0] sel;
      sel = FWD_RF;
      if (ex.valid) begin
         if (mem.valid && mem.reg_wen && !mem.mem_ren &&
             (mem.rd != '0) && (mem.rd == rs)) begin
            sel = FWD_MEM;
         end else if (wb.valid && wb.reg_wen &&
                      (wb.rd != '0) && (wb.rd == rs)) begin
            sel = FWD_WB;
         end
      end
      return sel;
   endfunction

   stage_t idex_q,  idex_d;
   stage_t exmem_q, exmem_d;
   stage_t memwb_q, memwb_d;
   stage_t id_bundle;

   logic id_reads_rs2;
   logic load_use;
   logic branch_flush;

   // Gather the ID inputs into one bundle.
   always_comb begin
      id_bundle            = bubble();
      id_bundle.valid      = id_valid;
      id_bundle.alu_op     = id_alu_op;
      id_bundle.alu_src    = id_alu_src;
      id_bundle.reg_wen    = id_reg_wen;
      id_bundle.reg_dst    = id_reg_dst;
      id_bundle.mem_ren    = id_mem_ren;
      id_bundle.mem_wen    = id_mem_wen;
      id_bundle.mem_to_reg = id_mem_to_reg;
      id_bundle.branch     = id_branch;
      id_bundle.rs1        = id_rs1;
      id_bundle.rs2        = id_rs2;
      id_bundle.rd         = id_rd;
   end

   // Hazard detection. rs2 matters only when the ID instruction reads it:
   // register-register ALU ops and stores (store data comes from rs2).
   // A taken branch in EX squashes ID, so it overrides the stall.
   always_comb begin
      id_reads_rs2 = !id_alu_src || id_mem_wen;
      load_use     = idex_q.valid && idex_q.mem_ren && (idex_q.rd != '0) &&
                     id_valid &&
                     ((idex_q.rd == id_rs1) ||
                      ((idex_q.rd == id_rs2) && id_reads_rs2));
      branch_flush = idex_q.valid && idex_q.branch && ex_taken;
      stall        = load_use && !branch_flush;
      flush_ifid   = branch_flush;
   end

   // Next-state for the three stage registers. ID/EX takes a bubble on a
   // flush, on a load-use stall, or when ID holds nothing. The later
   // stages always advance.
   always_comb begin
      idex_d = id_bundle;
      if (branch_flush || load_use || !id_valid) begin
         idex_d = bubble();
      end
      exmem_d = idex_q;
      memwb_d = exmem_q;
   end

   // Stage registers. Reset flushes all in-flight instructions to bubbles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idex_q  <= bubble();
         exmem_q <= bubble();
         memwb_q <= bubble();
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

   // EX operand forwarding selects.
   always_comb begin
      fwd_a = fwd_sel(idex_q, exmem_q, memwb_q, idex_q.rs1);
      fwd_b = fwd_sel(idex_q, exmem_q, memwb_q, idex_q.rs2);
   end

   assign ex_valid      = idex_q.valid;
   assign ex_alu_op     = idex_q.alu_op;
   assign ex_alu_src    = idex_q.alu_src;
   assign ex_reg_dst    = idex_q.reg_dst;
   assign ex_branch     = idex_q.branch;
   assign mem_valid     = exmem_q.valid;
   assign mem_ren       = exmem_q.mem_ren;
   assign mem_wen       = exmem_q.mem_wen;
   assign wb_valid      = memwb_q.valid;
   assign wb_reg_wen    = memwb_q.reg_wen;
   assign wb_mem_to_reg = memwb_q.mem_to_reg;
   assign wb_rd         = memwb_q.rd;

   // MEM/WB keeps the full bundle, but only part of it is visible on the
   // ports. This reduction gathers the remaining bits in one place.
   logic unused_wb_fields;
   assign unused_wb_fields = ^memwb_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe. It runs directed scenarios and then randomized
// traffic. Every cycle is compared against a reference model that holds
// the in-flight instructions as a list.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       v;
    logic [2:0] op;
    logic       src, wen, dst, mren, mwen, m2r, br;
    logic [3:0] rs1, rs2, rd;
  } ins_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       id_valid, id_alu_src, id_reg_wen, id_reg_dst, id_mem_ren;
  logic       id_mem_wen, id_mem_to_reg, id_branch, ex_taken;
  logic [2:0] id_alu_op;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic       ex_valid, ex_alu_src, ex_reg_dst, ex_branch;
  logic [2:0] ex_alu_op;
  logic       mem_valid, mem_ren, mem_wen;
  logic       wb_valid, wb_reg_wen, wb_mem_to_reg;
  logic [3:0] wb_rd;
  logic       stall, flush_ifid;
  logic [1:0] fwd_a, fwd_b;

  ctrl_pipe #(.RW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_reg_wen(id_reg_wen), .id_reg_dst(id_reg_dst), .id_mem_ren(id_mem_ren),
    .id_mem_wen(id_mem_wen), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch),
    .mem_valid(mem_valid), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .wb_valid(wb_valid), .wb_reg_wen(wb_reg_wen), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd), .stall(stall), .flush_ifid(flush_ifid),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // flight[0] is EX, flight[1] is MEM, flight[2] is WB.
  ins_t flight[3];
  logic m_stall, m_flush;

  function automatic ins_t bubble();
    ins_t b;
    b = '0;
    b.m2r = 1'b1;
    b.op = 3'b000;
    return b;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [3:0] rs);
    if (!flight[0].v) return 2'b00;
    if (flight[1].v && flight[1].wen && !flight[1].mren && flight[1].rd != 0 && flight[1].rd == rs)
      return 2'b01;
    if (flight[2].v && flight[2].wen && flight[2].rd != 0 && flight[2].rd == rs)
      return 2'b10;
    return 2'b00;
  endfunction

  // Values seen on the last stepped cycle, for directed checks.
  logic g_stall, g_flush, g_ex_valid, g_wb_wen, g_mem_wen;
  logic [3:0] g_wb_rd;
  logic [1:0] g_fwd_a;

  // ---------------- driver ----------------
  // One cycle: drive inputs after the falling edge, then compare all outputs
  // with the model. At the rising edge, advance the model.
  task automatic step(input ins_t id, input logic taken, input logic rst);
    logic lu;
    @(negedge clk);
    rst_n = ~rst; ex_taken = taken;
    id_valid = id.v; id_alu_op = id.op; id_alu_src = id.src; id_reg_wen = id.wen;
    id_reg_dst = id.dst; id_mem_ren = id.mren; id_mem_wen = id.mwen;
    id_mem_to_reg = id.m2r; id_branch = id.br;
    id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd;
    #1;
    m_flush = flight[0].v && flight[0].br && taken;
    lu = flight[0].v && flight[0].mren && flight[0].rd != 0 && id.v &&
         (flight[0].rd == id.rs1 || (flight[0].rd == id.rs2 && (!id.src || id.mwen)));
    m_stall = lu && !m_flush;
    check_eq("ex_valid", ex_valid, flight[0].v);
    check_eq("ex_alu_op", ex_alu_op, flight[0].op);
    check_eq("ex_alu_src", ex_alu_src, flight[0].src);
    check_eq("ex_reg_dst", ex_reg_dst, flight[0].dst);
    check_eq("ex_branch", ex_branch, flight[0].br);
    check_eq("mem_valid", mem_valid, flight[1].v);
    check_eq("mem_ren", mem_ren, flight[1].mren);
    check_eq("mem_wen", mem_wen, flight[1].mwen);
    check_eq("wb_valid", wb_valid, flight[2].v);
    check_eq("wb_reg_wen", wb_reg_wen, flight[2].wen);
    check_eq("wb_mem_to_reg", wb_mem_to_reg, flight[2].m2r);
    check_eq("wb_rd", wb_rd, flight[2].rd);
    check_eq("stall", stall, m_stall);
    check_eq("flush_ifid", flush_ifid, m_flush);
    check_eq("fwd_a", fwd_a, ref_fwd(flight[0].rs1));
    check_eq("fwd_b", fwd_b, ref_fwd(flight[0].rs2));
    g_stall = stall; g_flush = flush_ifid; g_ex_valid = ex_valid;
    g_wb_wen = wb_reg_wen; g_wb_rd = wb_rd; g_mem_wen = mem_wen; g_fwd_a = fwd_a;
    @(posedge clk);
    if (rst) begin
      flight[0] = bubble(); flight[1] = bubble(); flight[2] = bubble();
    end else begin
      flight[2] = flight[1];
      flight[1] = flight[0];
      flight[0] = (m_flush || lu || !id.v) ? bubble() : id;
    end
  endtask

  // ---------------- instruction builders ----------------
  function automatic ins_t mk(input logic [2:0] op, input logic src, wen, dst, mren, mwen, m2r, br,
                              input logic [3:0] rs1, rs2, rd);
    ins_t i;
    i.v = 1'b1; i.op = op; i.src = src; i.wen = wen; i.dst = dst; i.mren = mren;
    i.mwen = mwen; i.m2r = m2r; i.br = br; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    return i;
  endfunction

  function automatic ins_t r_op(input logic [2:0] op, input logic [3:0] rs1, rs2, rd);
    return mk(op, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rs1, rs2, rd);
  endfunction
  function automatic ins_t lw(input logic [3:0] rs1, rd);
    return mk(3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, rs1, 4'd0, rd);
  endfunction
  function automatic ins_t sw(input logic [3:0] rs1, rs2);
    return mk(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rs1, rs2, 4'd0);
  endfunction
  function automatic ins_t beq(input logic [3:0] rs1, rs2);
    return mk(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rs1, rs2, 4'd0);
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    case ($urandom_range(0, 4))
      0: i = r_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      1: i = lw(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      2: i = sw(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      3: i = beq(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      default: i = mk(3'($urandom_range(0, 7)), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3)));
    endcase
    i.v = ($urandom_range(0, 7) != 0);
    return i;
  endfunction

  // ---------------- stimulus ----------------
  ins_t nop, cur;
  initial begin
    nop = bubble();
    rst_n = 1'b0; ex_taken = 1'b0; id_valid = 1'b0;
    flight[0] = bubble(); flight[1] = bubble(); flight[2] = bubble();

    // Reset for 2 cycles, then idle.
    step(nop, 1'b0, 1'b1);
    step(nop, 1'b0, 1'b1);
    step(nop, 1'b0, 1'b0);
    check_eq("reset_ex_valid", g_ex_valid, 1'b0);
    check_eq("reset_stall", g_stall, 1'b0);
    check_eq("reset_mem_wen", g_mem_wen, 1'b0);
    check_eq("reset_fwd_a", g_fwd_a, 2'b00);

    // ADD r3,r1,r2 then SUB r4,r3,r1.
    step(r_op(3'b000, 4'd1, 4'd2, 4'd3), 1'b0, 1'b0);
    step(r_op(3'b001, 4'd3, 4'd1, 4'd4), 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0);
    check_eq("add_sub_fwd_a", g_fwd_a, 2'b01);
    step(nop, 1'b0, 1'b0);
    check_eq("add_wb_wen", g_wb_wen, 1'b1);
    check_eq("add_wb_rd", g_wb_rd, 4'd3);
    step(nop, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0);

    // LW r5 then ADD r6,r5,r2: one stall, bubble, then forward from WB.
    step(lw(4'd1, 4'd5), 1'b0, 1'b0);
    step(r_op(3'b000, 4'd5, 4'd2, 4'd6), 1'b0, 1'b0);
    check_eq("lu_stall", g_stall, 1'b1);
    step(r_op(3'b000, 4'd5, 4'd2, 4'd6), 1'b0, 1'b0);
    check_eq("lu_stall_once", g_stall, 1'b0);
    check_eq("lu_bubble", g_ex_valid, 1'b0);
    step(nop, 1'b0, 1'b0);
    check_eq("lu_fwd_a", g_fwd_a, 2'b10);
    step(nop, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0);

    // LW r5 then SLL r6,r2,imm with rs2=5 and alu_src=1: no stall.
    step(lw(4'd1, 4'd5), 1'b0, 1'b0);
    step(mk(3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd5, 4'd6), 1'b0, 1'b0);
    check_eq("sll_no_stall", g_stall, 1'b0);

    // LW r7 followed by BEQ, then a consumer of r7 while BEQ is taken in EX.
    step(lw(4'd1, 4'd7), 1'b0, 1'b0);
    step(beq(4'd1, 4'd2), 1'b0, 1'b0);
    step(r_op(3'b000, 4'd7, 4'd7, 4'd8), 1'b1, 1'b0);
    check_eq("beq_flush", g_flush, 1'b1);
    check_eq("beq_stall", g_stall, 1'b0);
    step(nop, 1'b0, 1'b0);
    check_eq("beq_bubble", g_ex_valid, 1'b0);

    // Load to r0 followed by a reader of r0: no stall, no forwarding.
    step(lw(4'd1, 4'd0), 1'b0, 1'b0);
    step(r_op(3'b000, 4'd0, 4'd0, 4'd9), 1'b0, 1'b0);
    check_eq("r0_no_stall", g_stall, 1'b0);
    step(nop, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0);
    check_eq("r0_fwd_a", g_fwd_a, 2'b00);

    // Reset while SW is in EX: no memory write afterwards.
    step(sw(4'd1, 4'd2), 1'b0, 1'b0);
    step(nop, 1'b0, 1'b1);
    step(nop, 1'b0, 1'b0);
    check_eq("rst_sw_mem_wen", g_mem_wen, 1'b0);

    // Randomized traffic. A stalled instruction is presented again.
    cur = rand_ins();
    for (int c = 0; c < 3000; c++) begin
      step(cur, 1'($urandom_range(0, 1)), ($urandom_range(0, 60) == 0));
      if (!m_stall) cur = rand_ins();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
